// File: rtl/alu_logic_dispatch.sv
// alu_logic_dispatch: 2-entry op FIFO feeding a registered logical unit, results returned over valid/ready
module alu_logic_dispatch #(
  parameter int N = 4,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] in_opcode,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic [N-1:0] lu_a,
  output logic [N-1:0] lu_b,
  output logic [M-2:0] lu_instr,
  input  logic [N-1:0] lu_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_zero,
  output logic         out_err
);
  typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, HOLD} state_t;
  state_t state, state_nx;
  logic [M+2*N-1:0] mem [2];
  logic [M+2*N-1:0] head;
  logic wp, rp, push, pop, capture;
  logic [1:0] cnt, cnt_nx;
  logic [N-1:0] held_a, res;
  logic held_err;
  assign push = in_valid & in_ready;
  assign cnt_nx = cnt + {1'b0, push} - {1'b0, pop};
  assign head = mem[rp];
  assign res = held_err ? held_a : lu_result;
  // next state; pop the head whenever the FSM starts a new op
  always_comb begin
    state_nx = state;
    pop = 1'b0;
    capture = 1'b0;
    case (state)
      IDLE: begin
        pop = cnt != 2'd0;
        state_nx = pop ? DRIVE : IDLE;
      end
      DRIVE: state_nx = CAPTURE;
      CAPTURE: begin
        capture = 1'b1;
        state_nx = HOLD;
      end
      default: begin
        pop = out_ready && cnt != 2'd0;
        state_nx = out_ready ? (pop ? DRIVE : IDLE) : HOLD;
      end
    endcase
  end
  // FIFO payload storage, no reset needed since occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= {in_opcode, in_a, in_b};
  end
  // FIFO pointers, occupancy and registered ready derived from next occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= 2'd0;
      in_ready <= 1'b0;
    end else begin
      wp <= wp ^ push;
      rp <= rp ^ pop;
      cnt <= cnt_nx;
      in_ready <= cnt_nx != 2'd2;
    end
  end
  // FSM state, logical-unit drive registers and downstream result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lu_a <= '0;
      lu_b <= '0;
      lu_instr <= '0;
      held_a <= '0;
      held_err <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_zero <= 1'b0;
      out_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (pop) begin
        lu_a <= head[2*N-1:N];
        lu_b <= head[N-1:0];
        lu_instr <= head[M+2*N-2:2*N];
        held_a <= head[2*N-1:N];
        held_err <= head[M+2*N-1];
      end
      if (capture) begin
        out_data <= res;
        out_zero <= ~|res;
        out_err <= held_err;
        out_valid <= 1'b1;
      end else if (state == HOLD && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_logic_dispatch.sv
// tb_alu_logic_dispatch: directed and random checks of the dispatcher against a queue-based reference model
module tb_alu_logic_dispatch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [3:0] in_opcode = '0;
  logic [3:0] in_a = '0;
  logic [3:0] in_b = '0;
  logic [3:0] lu_a, lu_b, lu_result, out_data;
  logic [2:0] lu_instr;
  logic out_valid, out_zero, out_err;
  logic out_ready = 1'b0;
  typedef struct {logic [3:0] d; logic z; logic e;} exp_t;
  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  int n_deliv = 0;
  always #5 clk = ~clk;
  alu_logic_dispatch #(.N(4), .M(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b),
    .lu_a(lu_a), .lu_b(lu_b), .lu_instr(lu_instr), .lu_result(lu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_zero(out_zero), .out_err(out_err)
  );
  function automatic logic [3:0] lu_f(input logic [2:0] i, input logic [3:0] a, input logic [3:0] b);
    case (i)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return ~(a ^ b);
      3'd6: return ~a;
      default: return b;
    endcase
  endfunction
  // registered logical unit stand-in
  always_ff @(posedge clk) lu_result <= rst ? 4'h0 : lu_f(lu_instr, lu_a, lu_b);
  function automatic exp_t model(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    exp_t x;
    x.e = op[3];
    x.d = op[3] ? a : lu_f(op[2:0], a, b);
    x.z = x.d == 4'h0;
    return x;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    logic acc, dlv;
    exp_t nx, x;
    acc = !rst && in_valid && in_ready;
    dlv = !rst && out_valid && out_ready;
    nx = model(in_opcode, in_a, in_b);
    if (dlv) begin
      if (q.size() == 0) chk("unexpected_output", 32'(out_data), 32'hdead);
      else begin
        x = q.pop_front();
        chk("sb_data", 32'(out_data), 32'(x.d));
        chk("sb_zero", 32'(out_zero), 32'(x.z));
        chk("sb_err", 32'(out_err), 32'(x.e));
        n_deliv++;
      end
    end
    @(posedge clk);
    #1;
    if (rst) q.delete();
    else if (acc) q.push_back(nx);
  endtask
  task automatic send(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    int n;
    n = 0;
    in_opcode = op;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("send_timeout", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
  endtask
  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    chk("wait_valid", 32'(out_valid), 1);
  endtask
  task automatic run_one(input string tag, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] ed, input logic ez, input logic ee);
    out_ready = 1'b1;
    send(op, a, b);
    wait_valid();
    chk({tag, "_data"}, 32'(out_data), 32'(ed));
    chk({tag, "_zero"}, 32'(out_zero), 32'(ez));
    chk({tag, "_err"}, 32'(out_err), 32'(ee));
    tick();
    chk({tag, "_valid_drop"}, 32'(out_valid), 0);
  endtask
  initial begin
    int n, sent, cyc;
    logic acc;
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_zero", 32'(out_zero), 0);
    chk("rst_out_err", 32'(out_err), 0);
    chk("rst_lu", 32'({lu_a, lu_b, lu_instr}), 0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", 32'(in_ready), 1);
    out_ready = 1'b1;
    in_opcode = 4'h0;
    in_a = 4'hC;
    in_b = 4'hA;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("lat_e0_valid", 32'(out_valid), 0);
    tick();
    chk("lat_e1_valid", 32'(out_valid), 0);
    chk("lat_e1_lu", 32'({lu_a, lu_b, lu_instr}), 32'({4'hC, 4'hA, 3'd0}));
    tick();
    chk("lat_e2_valid", 32'(out_valid), 0);
    tick();
    chk("lat_e3_valid", 32'(out_valid), 1);
    chk("and_data", 32'(out_data), 32'h8);
    chk("and_zero", 32'(out_zero), 0);
    chk("and_err", 32'(out_err), 0);
    tick();
    chk("and_valid_drop", 32'(out_valid), 0);
    run_one("xor", 4'h2, 4'h5, 4'h5, 4'h0, 1'b1, 1'b0);
    run_one("illegal", 4'h9, 4'h3, 4'hE, 4'h3, 1'b0, 1'b1);
    run_one("illegal_zero", 4'h8, 4'h0, 4'hF, 4'h0, 1'b1, 1'b1);
    run_one("or", 4'h1, 4'h5, 4'hA, 4'hF, 1'b0, 1'b0);
    out_ready = 1'b0;
    send(4'h0, 4'hF, 4'h3);
    send(4'h1, 4'h4, 4'h2);
    send(4'h2, 4'h6, 4'h6);
    chk("bp_full", 32'(in_ready), 0);
    for (int i = 0; i < 3; i++) tick();
    chk("bp_still_full", 32'(in_ready), 0);
    chk("bp_valid", 32'(out_valid), 1);
    chk("bp_head_data", 32'(out_data), 32'h3);
    out_ready = 1'b1;
    n = 0;
    while (q.size() > 0 && n < 50) begin
      tick();
      n++;
    end
    chk("bp_drained", q.size(), 0);
    chk("bp_ready_back", 32'(in_ready), 1);
    out_ready = 1'b0;
    send(4'h5, 4'h3, 4'h6);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_data", 32'(out_data), 32'hA);
      chk("hold_zero", 32'(out_zero), 0);
      chk("hold_err", 32'(out_err), 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pulse_valid_drop", 32'(out_valid), 0);
    tick();
    chk("pulse_valid_low", 32'(out_valid), 0);
    send(4'h0, 4'hF, 4'hF);
    send(4'h0, 4'h1, 4'h1);
    send(4'h0, 4'h2, 4'h2);
    chk("midrst_queued", 32'(in_ready), 0);
    rst = 1'b1;
    tick();
    chk("midrst_in_ready", 32'(in_ready), 0);
    chk("midrst_outs", 32'({out_valid, out_data, out_zero, out_err}), 0);
    chk("midrst_lu", 32'({lu_a, lu_b, lu_instr}), 0);
    tick();
    chk("midrst_in_ready2", 32'(in_ready), 0);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("no_stale_valid", 32'(out_valid), 0);
    end
    run_one("post_rst_nand", 4'h3, 4'hC, 4'hA, 4'h7, 1'b0, 1'b0);
    n_deliv = 0;
    sent = 0;
    cyc = 0;
    in_opcode = 4'($urandom);
    in_a = 4'($urandom);
    in_b = 4'($urandom);
    while ((sent < 1000 || q.size() > 0) && cyc < 30000) begin
      in_valid = sent < 1000 && $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      acc = in_valid && in_ready;
      tick();
      cyc++;
      if (acc) begin
        sent++;
        in_opcode = 4'($urandom);
        in_a = 4'($urandom);
        in_b = 4'($urandom);
      end
    end
    in_valid = 1'b0;
    chk("rand_sent", sent, 1000);
    chk("rand_delivered", n_deliv, 1000);
    chk("rand_queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
